seq_branch_cmp: RTL and testbench
=================================

Name: seq_branch_cmp

Overview:
Parametrised multi-cycle operand comparator for branch resolution in the pipelined datapath, successor to the single-cycle 32-bit equality check.
- Supports equality, inequality, and signed and unsigned magnitude modes.
- Compares CHUNK bits per cycle, MSB chunk first, and terminates early on the first differing chunk.
- Uses a start/busy/done handshake, with a flush input so the hazard unit can squash an in-flight compare.

Parameters:
- WIDTH, 32, operand width in bits.
- CHUNK, 8, bits compared per cycle. Must divide WIDTH; N = WIDTH/CHUNK.
- CW, $clog2(N)+1, width of the ncmp counter output.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only when state is IDLE or DONE.
- flush  in  1  synchronous squash of the in-flight compare.
- mode  in  3  compare mode, captured at start.
- a  in  WIDTH  operand A, captured at start.
- b  in  WIDTH  operand B, captured at start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the result is valid.
- result  out  1  branch condition for the captured mode.
- eq  out  1  captured operands are equal.
- lt  out  1  A < B (signed for modes 010/011, unsigned otherwise).
- ncmp  out  CW  number of chunks evaluated for the last result.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset state: state=IDLE; busy, done, result, eq, lt and ncmp all 0. Reset asserted mid-RUN takes effect immediately; no done is produced.
- Mode encoding:
  - 000 EQ (result=eq); 001 NE (result=!eq).
  - 010 LT signed (result=lt); 011 GE signed (result=!lt).
  - 100 LTU (result=lt); 101 GEU (result=!lt).
  - 110/111 reserved: result=0; eq, lt and ncmp are still computed normally.
- States: IDLE, RUN, DONE.
- IDLE or DONE, start=1, flush=0:
  - Capture a, b and mode into internal registers; set idx=N-1, ncmp=0.
  - Go to RUN. eq, lt and result keep their old values until the new done.
- RUN, each edge: compare captured chunk idx (bits idx*CHUNK+CHUNK-1 : idx*CHUNK); ncmp increments.
  - Signed modes only: the MSB chunk (idx=N-1) is compared with its top bit inverted. All other chunks are compared unsigned.
  - Chunks differ: eq=0, lt=(chunkA<chunkB), result updated, go to DONE.
  - Chunks equal and idx==0: eq=1, lt=0, result updated, go to DONE.
  - Otherwise: idx decrements, stay in RUN.
- DONE: done=1 for exactly one cycle, busy=0.
  - Next edge goes to IDLE, or to RUN if start=1 (back-to-back request accepted).
- Latency: done is high in the k-th cycle after the start edge, where k = number of chunks evaluated (1..N). Equal operands give k=N.
- start while in RUN is ignored; there is no queueing.
- a, b and mode changes after capture have no effect.
- flush=1 at any edge goes to IDLE:
  - Any RUN compare is discarded and done is not asserted.
  - eq, lt, result and ncmp hold their last completed values.
- flush and start on the same edge: flush wins; start is dropped.
- result, eq, lt and ncmp are stable from done until the next completed compare.

Decomposition:
- Shared package holds:
  - the mode encoding localparams (CMP_EQ, CMP_NE, CMP_LT, CMP_GE, CMP_LTU, CMP_GEU);
  - the state encoding (ST_IDLE, ST_RUN, ST_DONE).
- One sub-module, chunk_cmp: combinational, parametrised by CHUNK.
  - Inputs: two chunks and a signed_top flag.
  - Outputs: chunk_eq and chunk_lt.
- FSM, capture registers and mode decode live in seq_branch_cmp.

Test Plan:
All scenarios use WIDTH=32, CHUNK=8.
1. a=b=32'h12345678, mode EQ, 1-cycle start → done 4 cycles after the start edge; result=1, eq=1, lt=0, ncmp=4. Repeat with mode NE → result=0.
2. a=32'h80000000, b=32'h00000001:
   - mode LT → done after 1 cycle; result=1, lt=1, ncmp=1.
   - repeat with mode LTU → result=0, lt=0, ncmp=1.
3. a=32'h00000100, b=32'h00000200, mode GEU → differing chunk is idx 1; done after 3 cycles; result=0, lt=1, ncmp=3.
4. Start while busy:
   - From scenario 1 state, start a new compare and pulse start again in RUN → ignored; only one done.
   - Start another compare and assert flush 2 cycles into RUN → no done; busy=0 next cycle; result/eq/ncmp retain the scenario 1 values. flush and start together in IDLE → stays IDLE.
5. rst_n low mid-RUN (asynchronous, between edges) → busy, done, result, eq, lt and ncmp go to 0 immediately; after release, no done until a new start.
6. Back-to-back and reserved mode:
   - start asserted during the DONE cycle with new operands → accepted; second done follows with the correct value.
   - mode 3'b110 with a=b → result=0, eq=1, ncmp=4.

Source files
------------

// File: rtl/seq_branch_cmp_pkg.sv
// Shared encodings for the multi-cycle branch comparator: compare modes and FSM states.
package seq_branch_cmp_pkg;

    // Compare mode encoding (3'b110 / 3'b111 are reserved and always resolve to 0).
    localparam logic [2:0] CMP_EQ  = 3'b000;
    localparam logic [2:0] CMP_NE  = 3'b001;
    localparam logic [2:0] CMP_LT  = 3'b010;
    localparam logic [2:0] CMP_GE  = 3'b011;
    localparam logic [2:0] CMP_LTU = 3'b100;
    localparam logic [2:0] CMP_GEU = 3'b101;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cmpState;

endpackage

// File: rtl/seq_branch_cmp_chunk_cmp.sv
// Combinational compare of one operand chunk. When signed_top is set the chunk
// holds the operand sign bit, so that bit is inverted to turn a two's-complement
// ordering into an unsigned one.
module chunk_cmp #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] chunk_a,
    input  logic [CHUNK-1:0] chunk_b,
    input  logic             signed_top,
    output logic             chunk_eq,
    output logic             chunk_lt
);

    logic [CHUNK-1:0] topMask;
    logic [CHUNK-1:0] biasedA;
    logic [CHUNK-1:0] biasedB;

    // Bias the sign bit when required, then compare as unsigned.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        topMask            = '0;
        topMask[CHUNK-1]   = signed_top;
        biasedA            = chunk_a ^ topMask;
        biasedB            = chunk_b ^ topMask;
        chunk_eq           = (chunk_a == chunk_b);
        chunk_lt           = (biasedA < biasedB);
    end

endmodule

// File: rtl/seq_branch_cmp.sv
// Multi-cycle branch comparator. Operands are captured on start and compared one
// chunk per cycle from the most significant chunk down, stopping at the first
// chunk that differs. Results are only updated when a compare completes, so a
// flush or an ignored start never disturbs the last published result.
module seq_branch_cmp
    import seq_branch_cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int CW    = $clog2(WIDTH / CHUNK) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             result,
    output logic             eq,
    output logic             lt,
    output logic [CW-1:0]    ncmp
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    cmpState          state;
    cmpState          stateNext;

    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic [2:0]       modeReg;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0] chunkA;
    logic [CHUNK-1:0] chunkB;
    logic             signedTop;
    logic             chunkEq;
    logic             chunkLt;
    logic             lastChunk;
    logic             finish;
    logic             modeResult;
    logic             accept;

    assign chunkA    = aReg[idx*CHUNK +: CHUNK];
    assign chunkB    = bReg[idx*CHUNK +: CHUNK];
    assign signedTop = ((modeReg == CMP_LT) || (modeReg == CMP_GE)) && (idx == IW'(N - 1));
    assign lastChunk = (idx == '0);
    assign finish    = !chunkEq || lastChunk;
    assign accept    = (state != ST_RUN) && start && !flush;

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    chunk_cmp #(
        .CHUNK(CHUNK)
    ) u_chunk_cmp (
        .chunk_a    (chunkA),
        .chunk_b    (chunkB),
        .signed_top (signedTop),
        .chunk_eq   (chunkEq),
        .chunk_lt   (chunkLt)
    );

    // Branch condition for the captured mode, given the current chunk outcome.
    always_comb begin
        modeResult = 1'b0;
        case (modeReg)
            CMP_EQ:          modeResult = chunkEq;
            CMP_NE:          modeResult = !chunkEq;
            CMP_LT, CMP_LTU: modeResult = chunkLt;
            CMP_GE, CMP_GEU: modeResult = !chunkLt;
            default:         modeResult = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic; flush overrides everything, including a simultaneous start.
    always_comb begin
        stateNext = state;
        if (flush) begin
            stateNext = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) stateNext = ST_RUN;
                ST_RUN:  if (finish) stateNext = ST_DONE;
                ST_DONE: stateNext = start ? ST_RUN : ST_IDLE;
                default: stateNext = ST_IDLE;
            endcase
        end
    end

    // Operand capture, chunk walk and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aReg    <= '0;
            bReg    <= '0;
            modeReg <= CMP_EQ;
            idx     <= '0;
            cnt     <= '0;
            result  <= 1'b0;
            eq      <= 1'b0;
            lt      <= 1'b0;
            ncmp    <= '0;
        end else if (accept) begin
            aReg    <= a;
            bReg    <= b;
            modeReg <= mode;
            idx     <= IW'(N - 1);
            cnt     <= '0;
        end else if (state == ST_RUN && !flush) begin
            cnt <= cnt + CW'(1);
            if (finish) begin
                eq     <= chunkEq;
                lt     <= chunkLt;
                result <= modeResult;
                ncmp   <= cnt + CW'(1);
            end else begin
                idx <= idx - IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_branch_cmp.sv
// Scoreboard bench for seq_branch_cmp: each accepted request pushes its expected
// result and completion cycle; a negedge monitor pops and compares on every done.
module tb_seq_branch_cmp;
    import seq_branch_cmp_pkg::*;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int CW    = 3;

    typedef struct {
        logic          res;
        logic          eq;
        logic          lt;
        logic [CW-1:0] ncmp;
        int            cyc;
    } expT;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic             flush = 1'b0;
    logic [2:0]       mode  = 3'b000;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             busy;
    logic             done;
    logic             result;
    logic             eq;
    logic             lt;
    logic [CW-1:0]    ncmp;

    int  cyc   = 0;
    int  nVec  = 0;
    int  nFail = 0;
    expT sb[$];
    expT mon;

    seq_branch_cmp #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK),
        .CW   (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .flush (flush),
        .mode  (mode),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .result(result),
        .eq    (eq),
        .lt    (lt),
        .ncmp  (ncmp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge: drive a request for one edge, optionally record expectation.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] im,
                         input bit push, input logic er, input logic ee, input logic el,
                         input logic [CW-1:0] en);
        expT e;
        a     = ia;
        b     = ib;
        mode  = im;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e.res  = er;
            e.eq   = ee;
            e.lt   = el;
            e.ncmp = en;
            e.cyc  = cyc + int'(en);
            sb.push_back(e);
        end
    endtask

    // Bounded wait for done; returns at the negedge where done was seen.
    task automatic waitDone(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkZeroOutputs(input string tag);
        check({tag, "_busy"},   32'(busy),   32'd0);
        check({tag, "_done"},   32'(done),   32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_eq"},     32'(eq),     32'd0);
        check({tag, "_lt"},     32'(lt),     32'd0);
        check({tag, "_ncmp"},   32'(ncmp),   32'd0);
    endtask

    // Monitor: every done must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                nVec++;
                nFail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending compare", cyc);
            end else begin
                mon = sb.pop_front();
                check("result",  32'(result), 32'(mon.res));
                check("eq",      32'(eq),     32'(mon.eq));
                check("lt",      32'(lt),     32'(mon.lt));
                check("ncmp",    32'(ncmp),   32'(mon.ncmp));
                check("latency", cyc,         mon.cyc);
                check("busy_in_done", 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        #2;
        checkZeroOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: equal operands walk all four chunks
        issue(32'h12345678, 32'h12345678, CMP_EQ, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4);
        @(negedge clk);
        check("s1_busy_in_run", 32'(busy), 32'd1);
        waitDone("s1_eq");
        idle(1);
        issue(32'h12345678, 32'h12345678, CMP_NE, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4);
        waitDone("s1_ne");
        idle(1);

        // 2: sign bit decides signed vs unsigned on the first chunk
        issue(32'h80000000, 32'h00000001, CMP_LT, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1);
        waitDone("s2_lt");
        idle(1);
        issue(32'h80000000, 32'h00000001, CMP_LTU, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        waitDone("s2_ltu");
        idle(1);

        // 3: difference in chunk 1
        issue(32'h00000100, 32'h00000200, CMP_GEU, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3);
        waitDone("s3_geu");
        idle(1);

        // 4a: a second start while running is ignored
        issue(32'h12345678, 32'h12345678, CMP_EQ, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4);
        @(negedge clk);
        a     = 32'h0;
        b     = 32'h1;
        mode  = CMP_NE;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone("s4_ignored_start");
        idle(6);
        check("s4_idle_busy", 32'(busy), 32'd0);

        // 4b: flush two cycles into a run discards it and keeps old results
        issue(32'h00000001, 32'h00000002, CMP_LTU, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("s4_flush_busy",   32'(busy),   32'd0);
        check("s4_flush_done",   32'(done),   32'd0);
        check("s4_flush_result", 32'(result), 32'd1);
        check("s4_flush_eq",     32'(eq),     32'd1);
        check("s4_flush_lt",     32'(lt),     32'd0);
        check("s4_flush_ncmp",   32'(ncmp),   32'd4);
        idle(6);

        // 4c: flush and start together in IDLE stays idle
        a     = 32'h0;
        b     = 32'h0;
        mode  = CMP_EQ;
        flush = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("s4_flush_start_busy", 32'(busy), 32'd0);
        idle(6);

        // 5: asynchronous reset mid-run
        issue(32'hAAAAAAAA, 32'hAAAAAAAA, CMP_EQ, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkZeroOutputs("s5_async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(8);
        check("s5_after_busy", 32'(busy), 32'd0);
        check("s5_after_done", 32'(done), 32'd0);

        // 6: back-to-back request from DONE, then reserved mode
        issue(32'h00000005, 32'h00000003, CMP_GE, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4);
        waitDone("s6_first");
        issue(32'hFF000000, 32'h01000000, CMP_GE, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
        waitDone("s6_back_to_back");
        idle(1);
        issue(32'hCAFEBABE, 32'hCAFEBABE, 3'b110, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4);
        waitDone("s6_reserved");
        idle(3);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
